hpdmc_wrpath: RTL and testbench

- Write-side datapath of the HPDMC DDR PHY; counterpart of the 16-bit input DDR capture path.
- On a write command, pulls BURST_WORDS 32-bit words from the controller's data interface.
- Splits each word into rising/falling 16-bit halves with byte masks, and generates DQS patterns and DQ/DQS output enables with preamble and postamble.
- Outputs are registered and feed 16-bit ODDR2 banks in the PHY top level.

---
 rtl/hpdmc_wrpath_pkg.sv | 45 ++++
 rtl/hpdmc_wrpath_if.sv | 14 +
 rtl/hpdmc_wrpath.sv | 155 +++++++++++++++
 tb/tb_hpdmc_wrpath.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdmc_wrpath_pkg.sv
// Shared types and constants for the HPDMC write datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hpdmc_wr_pkg;

    localparam int DQ_W   = 16;
    localparam int DM_W   = 2;
    localparam int WORD_W = 32;
    localparam int MASK_W = WORD_W / 8;

    // Values driven into a burst slot that had no write data.
    localparam logic [DQ_W-1:0] UNDERRUN_DQ = '0;
    localparam logic [DM_W-1:0] UNDERRUN_DM = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PRE   = 3'd2,
        ST_BURST = 3'd3,
        ST_POST  = 3'd4
    } state_t;

    // DQS/DQ control pattern presented while in a given state.
    typedef struct packed {
        logic dqs_oe;
        logic dqs_q0;
        logic dqs_q1;
        logic dq_oe;
    } dqs_pat_t;

    localparam dqs_pat_t PAT_IDLE  = '{dqs_oe: 1'b0, dqs_q0: 1'b0, dqs_q1: 1'b0, dq_oe: 1'b0};
    localparam dqs_pat_t PAT_PRE   = '{dqs_oe: 1'b1, dqs_q0: 1'b0, dqs_q1: 1'b0, dq_oe: 1'b0};
    localparam dqs_pat_t PAT_BURST = '{dqs_oe: 1'b1, dqs_q0: 1'b1, dqs_q1: 1'b0, dq_oe: 1'b1};
    localparam dqs_pat_t PAT_POST  = '{dqs_oe: 1'b1, dqs_q0: 1'b0, dqs_q1: 1'b0, dq_oe: 1'b0};

    function automatic dqs_pat_t pat_of(input state_t s);
        case (s)
            ST_PRE:   pat_of = PAT_PRE;
            ST_BURST: pat_of = PAT_BURST;
            ST_POST:  pat_of = PAT_POST;
            default:  pat_of = PAT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hpdmc_wrpath_if.sv
// Write-data handshake between the memory controller and the write datapath.
// Latency: none (wires only).
// Backpressure: din_ready marks the slots in which a word is consumed; no stall.
interface hpdmc_wrpath_if;
    import hpdmc_wr_pkg::*;

    logic                din_valid;
    logic                din_ready;
    logic [WORD_W-1:0]   din_data;
    logic [MASK_W-1:0]   din_mask;

    modport master (output din_valid, output din_data, output din_mask, input din_ready);
    modport slave  (input din_valid, input din_data, input din_mask, output din_ready);
endinterface

// File: rtl/hpdmc_wrpath.sv
// DDR write datapath: burst sequencer, slot splitter and DQS/OE generator (HPDMC_WR_UNDERRUN_CNT_EN adds underrun_cnt).
// Latency: preamble WR_LATENCY+1 cycles after wr_start; word taken in cycle n is driven in cycle n+1.
// Backpressure: none; DDR timing is fixed, a slot without valid data is filled and flagged as underrun.
module hpdmc_wrpath
    import hpdmc_wr_pkg::*;
#(
    parameter int BURST_WORDS = 4,
    parameter int WR_LATENCY  = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               wr_start,
    output logic               wr_busy,
    hpdmc_wrpath_if.slave      din,
    output logic [DQ_W-1:0]    dq_q0,
    output logic [DQ_W-1:0]    dq_q1,
    output logic [DM_W-1:0]    dm_q0,
    output logic [DM_W-1:0]    dm_q1,
    output logic               dq_oe,
    output logic               dqs_q0,
    output logic               dqs_q1,
    output logic               dqs_oe,
`ifdef HPDMC_WR_UNDERRUN_CNT_EN
    output logic [7:0]         underrun_cnt,
`endif
    output logic               underrun,
    input  logic               underrun_clr
);

    localparam logic [2:0] LAT_LAST   = (WR_LATENCY == 0) ? 3'd0 : 3'(WR_LATENCY - 1);
    localparam logic [2:0] BURST_LAST = 3'(BURST_WORDS - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    dqs_pat_t   pat_q;
    logic       slot;
    logic       slot_empty;

    // A word is consumed in PRE and in every BURST cycle except the last one.
    assign slot          = (state == ST_PRE) || ((state == ST_BURST) && (cnt != BURST_LAST));
    assign slot_empty    = slot && !din.din_valid;
    assign din.din_ready = slot;

    // Next-state and shared WAIT/BURST cycle counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt = 3'd0;
                if (wr_start) begin
                    state_nxt = (WR_LATENCY == 0) ? ST_PRE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == LAT_LAST) begin
                    state_nxt = ST_PRE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            ST_PRE: begin
                state_nxt = ST_BURST;
                cnt_nxt   = 3'd0;
            end
            ST_BURST: begin
                if (cnt == BURST_LAST) begin
                    state_nxt = ST_POST;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            ST_POST: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // State, counter and control outputs registered from the upcoming state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            pat_q   <= PAT_IDLE;
            wr_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pat_q   <= pat_of(state_nxt);
            wr_busy <= (state_nxt != ST_IDLE);
        end
    end

    assign dqs_oe = pat_q.dqs_oe;
    assign dqs_q0 = pat_q.dqs_q0;
    assign dqs_q1 = pat_q.dqs_q1;
    assign dq_oe  = pat_q.dq_oe;

    // Slot data register; holds the last word outside of consuming slots.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq_q0 <= '0;
            dq_q1 <= '0;
            dm_q0 <= '0;
            dm_q1 <= '0;
        end else if (slot) begin
            if (din.din_valid) begin
                dq_q0 <= din.din_data[DQ_W-1:0];
                dq_q1 <= din.din_data[WORD_W-1:DQ_W];
                dm_q0 <= din.din_mask[DM_W-1:0];
                dm_q1 <= din.din_mask[MASK_W-1:DM_W];
            end else begin
                dq_q0 <= UNDERRUN_DQ;
                dq_q1 <= UNDERRUN_DQ;
                dm_q0 <= UNDERRUN_DM;
                dm_q1 <= UNDERRUN_DM;
            end
        end
    end

    // Sticky underrun flag; a new underrun outranks a simultaneous clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underrun <= 1'b0;
        end else if (slot_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

`ifdef HPDMC_WR_UNDERRUN_CNT_EN
    // Saturating underrun slot counter; increment with clear restarts at one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underrun_cnt <= 8'd0;
        end else if (slot_empty) begin
            if (underrun_clr) begin
                underrun_cnt <= 8'd1;
            end else if (underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end else if (underrun_clr) begin
            underrun_cnt <= 8'd0;
        end
    end
`endif

endmodule

// File: tb/tb_hpdmc_wrpath.sv
// Directed bench for hpdmc_wrpath (default and WR_LATENCY=0/BURST_WORDS=1 instances).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench drives words into the slots where din_ready is expected.
module tb_hpdmc_wrpath;
    import hpdmc_wr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance: BURST_WORDS=4, WR_LATENCY=1.
    hpdmc_wrpath_if bus ();
    logic        wr_start, underrun_clr;
    logic        wr_busy, dq_oe, dqs_q0, dqs_q1, dqs_oe, underrun;
    logic [15:0] dq_q0, dq_q1;
    logic [1:0]  dm_q0, dm_q1;
`ifdef HPDMC_WR_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt, underrun_cnt0;
`endif

    hpdmc_wrpath #(.BURST_WORDS(4), .WR_LATENCY(1)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr_start(wr_start), .wr_busy(wr_busy),
        .din(bus.slave), .dq_q0(dq_q0), .dq_q1(dq_q1), .dm_q0(dm_q0), .dm_q1(dm_q1),
        .dq_oe(dq_oe), .dqs_q0(dqs_q0), .dqs_q1(dqs_q1), .dqs_oe(dqs_oe),
`ifdef HPDMC_WR_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    // Second instance: WR_LATENCY=0, BURST_WORDS=1.
    hpdmc_wrpath_if bus0 ();
    logic        wr_start0;
    logic        wr_busy0, dq_oe0, dqs_q00, dqs_q10, dqs_oe0, underrun0;
    logic [15:0] dq0_q0, dq0_q1;
    logic [1:0]  dm0_q0, dm0_q1;

    hpdmc_wrpath #(.BURST_WORDS(1), .WR_LATENCY(0)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr_start(wr_start0), .wr_busy(wr_busy0),
        .din(bus0.slave), .dq_q0(dq0_q0), .dq_q1(dq0_q1), .dm_q0(dm0_q0), .dm_q1(dm0_q1),
        .dq_oe(dq_oe0), .dqs_q0(dqs_q00), .dqs_q1(dqs_q10), .dqs_oe(dqs_oe0),
`ifdef HPDMC_WR_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt0),
`endif
        .underrun(underrun0), .underrun_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic busy, input logic rdy, input logic soe,
                       input logic sq0, input logic doe);
        chk({tag, ".wr_busy"}, 32'(wr_busy), 32'(busy));
        chk({tag, ".din_ready"}, 32'(bus.din_ready), 32'(rdy));
        chk({tag, ".dqs_oe"}, 32'(dqs_oe), 32'(soe));
        chk({tag, ".dqs_q0"}, 32'(dqs_q0), 32'(sq0));
        chk({tag, ".dqs_q1"}, 32'(dqs_q1), 32'(1'b0));
        chk({tag, ".dq_oe"}, 32'(dq_oe), 32'(doe));
    endtask

    task automatic dat(input string tag, input logic [31:0] word, input logic [3:0] mask);
        chk({tag, ".dq"}, {dq_q1, dq_q0}, word);
        chk({tag, ".dm"}, 32'({dm_q1, dm_q0}), 32'(mask));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] wd [5];
    logic [3:0]  wm [5];

    initial begin
        wd = '{32'h1111_0000, 32'h3333_2222, 32'h5555_4444, 32'h7777_6666, 32'h0};
        wm = '{4'b0000, 4'b1001, 4'b0110, 4'b1111, 4'b0000};
        rst_n = 1'b0;
        wr_start = 1'b0; underrun_clr = 1'b0;
        bus.din_valid = 1'b0; bus.din_data = '0; bus.din_mask = '0;
        wr_start0 = 1'b0;
        bus0.din_valid = 1'b0; bus0.din_data = '0; bus0.din_mask = '0;

        // Reset state
        #2;
        ctl("rst", 0, 0, 0, 0, 0);
        dat("rst", 32'h0, 4'h0);
        chk("rst.underrun", 32'(underrun), 32'h0);
`ifdef HPDMC_WR_UNDERRUN_CNT_EN
        chk("rst.underrun_cnt", 32'(underrun_cnt), 32'h0);
`endif
        #20 rst_n = 1'b1;

        // Burst 1: clean, data held valid
        tick;                                    // cycle 0 IDLE
        ctl("b1.idle", 0, 0, 0, 0, 0);
        wr_start = 1'b1;
        tick;                                    // cycle 1 WAIT
        wr_start = 1'b0;
        ctl("b1.wait", 1, 0, 0, 0, 0);
        tick;                                    // cycle 2 PRE
        ctl("b1.pre", 1, 1, 1, 0, 0);
        bus.din_valid = 1'b1; bus.din_data = wd[0]; bus.din_mask = wm[0];
        for (int i = 0; i < 4; i++) begin
            tick;                                // cycles 3..6 BURST
            ctl("b1.burst", 1, (i < 3), 1, 1, 1);
            dat("b1.slot", wd[i], wm[i]);
            bus.din_data = wd[i+1]; bus.din_mask = wm[i+1];
        end
        tick;                                    // cycle 7 POST
        ctl("b1.post", 1, 0, 1, 0, 0);
        dat("b1.hold", wd[3], wm[3]);
        chk("b1.underrun", 32'(underrun), 32'h0);
        tick;                                    // cycle 8 IDLE: earliest restart
        ctl("b1.end", 0, 0, 0, 0, 0);

        // Burst 2: underrun in third slot, stray wr_start during BURST
        wr_start = 1'b1;
        tick;                                    // 9 WAIT
        wr_start = 1'b0;
        ctl("b2.wait", 1, 0, 0, 0, 0);
        tick;                                    // 10 PRE
        bus.din_data = 32'hAAAA_BBBB; bus.din_mask = 4'h0;
        tick;                                    // 11 B0
        dat("b2.s0", 32'hAAAA_BBBB, 4'h0);
        bus.din_data = 32'hCCCC_DDDD;
        wr_start = 1'b1;
        tick;                                    // 12 B1
        wr_start = 1'b0;
        dat("b2.s1", 32'hCCCC_DDDD, 4'h0);
        chk("b2.underrun_pre", 32'(underrun), 32'h0);
        bus.din_valid = 1'b0;
        tick;                                    // 13 B2
        ctl("b2.b2", 1, 1, 1, 1, 1);
        dat("b2.fill", 32'h0, 4'hF);
        chk("b2.underrun", 32'(underrun), 32'h1);
`ifdef HPDMC_WR_UNDERRUN_CNT_EN
        chk("b2.underrun_cnt", 32'(underrun_cnt), 32'h1);
`endif
        bus.din_valid = 1'b1; bus.din_data = 32'h1234_5678;
        tick;                                    // 14 B3
        dat("b2.s3", 32'h1234_5678, 4'h0);
        tick;                                    // 15 POST
        ctl("b2.post", 1, 0, 1, 0, 0);
        tick;                                    // 16 IDLE
        ctl("b2.idle", 0, 0, 0, 0, 0);
        tick;                                    // 17 still IDLE: stray start dropped
        ctl("b2.noqueue", 0, 0, 0, 0, 0);

        // Burst 3: clear vs. set in the same cycle, then clear alone
        wr_start = 1'b1;
        tick;                                    // 18 WAIT
        wr_start = 1'b0;
        tick;                                    // 19 PRE
        bus.din_valid = 1'b0; underrun_clr = 1'b1;
        tick;                                    // 20 B0
        chk("b3.set_wins", 32'(underrun), 32'h1);
        dat("b3.fill", 32'h0, 4'hF);
`ifdef HPDMC_WR_UNDERRUN_CNT_EN
        chk("b3.cnt_inc_wins", 32'(underrun_cnt), 32'h1);
`endif
        underrun_clr = 1'b0;
        bus.din_valid = 1'b1; bus.din_data = 32'h0F0F_F0F0; bus.din_mask = 4'hF;
        tick;                                    // 21 B1
        dat("b3.s1", 32'h0F0F_F0F0, 4'hF);
        chk("b3.sticky", 32'(underrun), 32'h1);
        underrun_clr = 1'b1; bus.din_data = 32'h0; bus.din_mask = 4'h0;
        tick;                                    // 22 B2
        underrun_clr = 1'b0;
        chk("b3.cleared", 32'(underrun), 32'h0);
`ifdef HPDMC_WR_UNDERRUN_CNT_EN
        chk("b3.cnt_cleared", 32'(underrun_cnt), 32'h0);
`endif
        tick;                                    // 23 B3
        dat("b3.s3", 32'h0, 4'h0);
        tick;                                    // 24 POST
        tick;                                    // 25 IDLE

        // Burst 4: asynchronous reset mid-BURST, then a clean burst
        wr_start = 1'b1;
        tick;                                    // WAIT
        wr_start = 1'b0;
        tick;                                    // PRE
        bus.din_data = wd[0]; bus.din_mask = wm[0];
        tick;                                    // B0
        tick;                                    // B1
        ctl("b4.b1", 1, 1, 1, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        ctl("b4.async_rst", 0, 0, 0, 0, 0);
        dat("b4.async_rst", 32'h0, 4'h0);
        #2 rst_n = 1'b1;
        tick;                                    // IDLE
        ctl("b5.idle", 0, 0, 0, 0, 0);
        wr_start = 1'b1;
        tick;                                    // WAIT
        wr_start = 1'b0;
        tick;                                    // PRE
        ctl("b5.pre", 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            ctl("b5.burst", 1, (i < 3), 1, 1, 1);
            dat("b5.slot", wd[i], wm[i]);
            bus.din_data = wd[i+1]; bus.din_mask = wm[i+1];
        end
        tick;                                    // POST
        ctl("b5.post", 1, 0, 1, 0, 0);
        tick;                                    // IDLE
        ctl("b5.end", 0, 0, 0, 0, 0);
        chk("b5.underrun", 32'(underrun), 32'h0);

`ifdef HPDMC_WR_UNDERRUN_CNT_EN
        // 75 empty bursts = 300 underrun slots: counter saturates
        bus.din_valid = 1'b0;
        for (int b = 0; b < 75; b++) begin
            wr_start = 1'b1;
            tick;
            wr_start = 1'b0;
            repeat (7) tick;
        end
        chk("sat.underrun_cnt", 32'(underrun_cnt), 32'hFF);
        bus.din_valid = 1'b1;
`endif

        // WR_LATENCY=0, BURST_WORDS=1 instance
        chk("l0.idle_busy", 32'(wr_busy0), 32'h0);
        wr_start0 = 1'b1;
        bus0.din_valid = 1'b1; bus0.din_data = 32'hBEEF_CAFE; bus0.din_mask = 4'b0110;
        tick;                                    // PRE directly
        wr_start0 = 1'b0;
        chk("l0.pre.dqs_oe", 32'(dqs_oe0), 32'h1);
        chk("l0.pre.dq_oe", 32'(dq_oe0), 32'h0);
        chk("l0.pre.ready", 32'(bus0.din_ready), 32'h1);
        chk("l0.pre.busy", 32'(wr_busy0), 32'h1);
        tick;                                    // single BURST cycle
        chk("l0.burst.ready", 32'(bus0.din_ready), 32'h0);
        chk("l0.burst.dq_oe", 32'(dq_oe0), 32'h1);
        chk("l0.burst.dqs_q0", 32'(dqs_q00), 32'h1);
        chk("l0.burst.dq", {dq0_q1, dq0_q0}, 32'hBEEF_CAFE);
        chk("l0.burst.dm", 32'({dm0_q1, dm0_q0}), 32'b0110);
        tick;                                    // POST
        chk("l0.post.ready", 32'(bus0.din_ready), 32'h0);
        chk("l0.post.dqs_oe", 32'(dqs_oe0), 32'h1);
        chk("l0.post.dq_oe", 32'(dq_oe0), 32'h0);
        tick;                                    // IDLE
        chk("l0.end.busy", 32'(wr_busy0), 32'h0);
        chk("l0.end.dqs_oe", 32'(dqs_oe0), 32'h0);
        chk("l0.underrun", 32'(underrun0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
